// File: rtl/core_run_ctrl_if.sv
// Register-dump stream between the run controller and its consumer.
// The controller drives valid/addr/data, the consumer answers with ready.
interface core_run_ctrl_if #(
   parameter int XLEN = 64,
   parameter int AW   = 5
);
   logic            dump_valid;
   logic            dump_ready;
   logic [AW-1:0]   dump_addr;
   logic [XLEN-1:0] dump_data;

   modport master (
      output dump_valid,
      output dump_addr,
      output dump_data,
      input  dump_ready
   );

   modport slave (
      input  dump_valid,
      input  dump_addr,
      input  dump_data,
      output dump_ready
   );
endinterface

// File: rtl/core_run_ctrl.sv
// Run controller for the RV64 Core: reset sequencing, clock-enable gating
// (free-run, single/burst step, PC breakpoint) and register-file dump.
// Optional feature macro: CORE_RUN_BREAKPOINT_EN builds in the breakpoint
// compare and the combinational core_ce gating; without it the breakpoint
// inputs are ignored.
module core_run_ctrl #(
   parameter int XLEN     = 64,
   parameter int NREG     = 32,
   parameter int RST_HOLD = 80,
   parameter int BURST_W  = 16,
   localparam int AW      = $clog2(NREG)
) (
   input  logic               clk,
   input  logic               aresetn,
   input  logic               step_i,
   input  logic               debug_mode_i,
   input  logic [BURST_W-1:0] burst_len_i,
   input  logic               bp_en_i,
   input  logic [XLEN-1:0]    bp_addr_i,
   input  logic [XLEN-1:0]    pc_i,
   input  logic               dump_req_i,
   input  logic [XLEN-1:0]    dbg_reg_data_i,
   output logic               core_rstn_o,
   output logic               core_ce_o,
   output logic               halted_o,
   output logic [AW-1:0]      dbg_reg_addr_o,
   output logic [31:0]        step_cnt_o,
   core_run_ctrl_if.master    dump_if
);

   localparam int CW = $clog2(RST_HOLD + 1);

   typedef enum logic [2:0] {RESET_HOLD, RUN, HALT, STEP, DUMP} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      rstCnt_q, rstCnt_d;
   logic               coreRstn_q, coreRstn_d;
   logic               stepSync1_q, stepSync2_q, stepSync3_q;
   logic               stepRise;
   logic [BURST_W-1:0] remain_q, remain_d;
   logic               firstStep_q, firstStep_d;
   logic               dumpPend_q, dumpPend_d;
   logic [AW-1:0]      dbgAddr_q, dbgAddr_d;
   logic [AW-1:0]      dumpAddr_q, dumpAddr_d;
   logic [XLEN-1:0]    dumpData_q, dumpData_d;
   logic               dumpValid_q, dumpValid_d;
   logic [31:0]        stepCnt_q, stepCnt_d;
   logic               bpHit;
   logic               coreCe;

`ifdef CORE_RUN_BREAKPOINT_EN
   assign bpHit = bp_en_i && (pc_i == bp_addr_i);
`else
   logic unusedBp;
   assign unusedBp = ^{bp_en_i, bp_addr_i, pc_i};
   assign bpHit    = 1'b0;
`endif

   // Bring the asynchronous step button into the clock domain; the third flop
   // only remembers the previous synchronized level for edge detection.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         stepSync1_q <= 1'b0;
         stepSync2_q <= 1'b0;
         stepSync3_q <= 1'b0;
      end else begin
         stepSync1_q <= step_i;
         stepSync2_q <= stepSync1_q;
         stepSync3_q <= stepSync2_q;
      end
   end

   assign stepRise = stepSync2_q & ~stepSync3_q;

   // Next-state logic: mode sequencing, burst counting, dump beat handshake
   // and the combinational clock enable (a breakpoint hit kills the cycle).
   always_comb begin
      state_d     = state_q;
      rstCnt_d    = rstCnt_q;
      coreRstn_d  = coreRstn_q;
      remain_d    = remain_q;
      firstStep_d = firstStep_q;
      dumpPend_d  = dumpPend_q | (dump_req_i && (state_q != RESET_HOLD));
      dbgAddr_d   = dbgAddr_q;
      dumpAddr_d  = dumpAddr_q;
      dumpData_d  = dumpData_q;
      dumpValid_d = dumpValid_q;
      coreCe      = 1'b0;
      case (state_q)
         RESET_HOLD: begin
            if (rstCnt_q == CW'(RST_HOLD - 1)) begin
               coreRstn_d = 1'b1;
               state_d    = debug_mode_i ? HALT : RUN;
            end else begin
               rstCnt_d = rstCnt_q + CW'(1);
            end
         end
         RUN: begin
            coreCe = !bpHit;
            if (debug_mode_i || bpHit) begin
               state_d = HALT;
            end
         end
         HALT: begin
            if (dumpPend_q) begin
               state_d     = DUMP;
               dumpPend_d  = 1'b0;
               dbgAddr_d   = '0;
               dumpValid_d = 1'b0;
            end else if (stepRise) begin
               state_d     = STEP;
               remain_d    = (burst_len_i == '0) ? BURST_W'(1) : burst_len_i;
               firstStep_d = 1'b1;
            end else if (!debug_mode_i) begin
               state_d = RUN;
            end
         end
         STEP: begin
            firstStep_d = 1'b0;
            if (bpHit && !firstStep_q) begin
               state_d = HALT;
            end else begin
               coreCe = 1'b1;
               if (remain_q == BURST_W'(1)) begin
                  state_d = HALT;
               end else begin
                  remain_d = remain_q - BURST_W'(1);
               end
            end
         end
         DUMP: begin
            if (!dumpValid_q) begin
               dumpValid_d = 1'b1;
               dumpAddr_d  = dbgAddr_q;
               dumpData_d  = dbg_reg_data_i;
            end else if (dump_if.dump_ready) begin
               dumpValid_d = 1'b0;
               if (dbgAddr_q == AW'(NREG - 1)) begin
                  state_d   = HALT;
                  dbgAddr_d = '0;
               end else begin
                  dbgAddr_d = dbgAddr_q + AW'(1);
               end
            end
         end
         default: state_d = RESET_HOLD;
      endcase
      stepCnt_d = coreCe ? stepCnt_q + 32'd1 : stepCnt_q;
   end

   // State and datapath registers; reset drops everything back to RESET_HOLD.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= RESET_HOLD;
         rstCnt_q    <= '0;
         coreRstn_q  <= 1'b0;
         remain_q    <= '0;
         firstStep_q <= 1'b0;
         dumpPend_q  <= 1'b0;
         dbgAddr_q   <= '0;
         dumpAddr_q  <= '0;
         dumpData_q  <= '0;
         dumpValid_q <= 1'b0;
         stepCnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         rstCnt_q    <= rstCnt_d;
         coreRstn_q  <= coreRstn_d;
         remain_q    <= remain_d;
         firstStep_q <= firstStep_d;
         dumpPend_q  <= dumpPend_d;
         dbgAddr_q   <= dbgAddr_d;
         dumpAddr_q  <= dumpAddr_d;
         dumpData_q  <= dumpData_d;
         dumpValid_q <= dumpValid_d;
         stepCnt_q   <= stepCnt_d;
      end
   end

   assign core_rstn_o        = coreRstn_q;
   assign core_ce_o          = coreCe;
   assign halted_o           = (state_q == HALT) || (state_q == DUMP);
   assign dbg_reg_addr_o     = dbgAddr_q;
   assign step_cnt_o         = stepCnt_q;
   assign dump_if.dump_valid = dumpValid_q;
   assign dump_if.dump_addr  = dumpAddr_q;
   assign dump_if.dump_data  = dumpData_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed testbench for core_run_ctrl: reset sequencing, step bursts,
// breakpoint behaviour (either build), register dump and mid-operation reset.
module tb_core_run_ctrl;

   localparam int XLEN     = 64;
   localparam int NREG     = 32;
   localparam int AW       = 5;
   localparam int RST_HOLD = 80;
   localparam int BURST_W  = 16;

   logic               clk;
   logic               aresetn;
   logic               step;
   logic               debugMode;
   logic [BURST_W-1:0] burstLen;
   logic               bpEn;
   logic [XLEN-1:0]    bpAddr;
   logic [XLEN-1:0]    pc;
   logic               dumpReq;
   logic [XLEN-1:0]    dbgRegData;
   logic               coreRstn;
   logic               coreCe;
   logic               halted;
   logic [AW-1:0]      dbgRegAddr;
   logic [31:0]        stepCnt;

   int errors = 0;
   int checks = 0;
   int stepExp = 0;
   int ceQ[$];
   logic [XLEN+AW-1:0] dumpQ[$];

   core_run_ctrl_if #(.XLEN(XLEN), .AW(AW)) dumpBus ();

   core_run_ctrl #(
      .XLEN(XLEN), .NREG(NREG), .RST_HOLD(RST_HOLD), .BURST_W(BURST_W)
   ) dut (
      .clk(clk),
      .aresetn(aresetn),
      .step_i(step),
      .debug_mode_i(debugMode),
      .burst_len_i(burstLen),
      .bp_en_i(bpEn),
      .bp_addr_i(bpAddr),
      .pc_i(pc),
      .dump_req_i(dumpReq),
      .dbg_reg_data_i(dbgRegData),
      .core_rstn_o(coreRstn),
      .core_ce_o(coreCe),
      .halted_o(halted),
      .dbg_reg_addr_o(dbgRegAddr),
      .step_cnt_o(stepCnt),
      .dump_if(dumpBus)
   );

   // Register file model: register i holds i*0x1111.
   assign dbgRegData = 64'(dbgRegAddr) * 64'h1111;

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so a stuck design still ends the run.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, ".core_rstn"}, 64'(coreRstn), 64'd0);
      checkOutput({tag, ".core_ce"}, 64'(coreCe), 64'd0);
      checkOutput({tag, ".halted"}, 64'(halted), 64'd0);
      checkOutput({tag, ".dump_valid"}, 64'(dumpBus.dump_valid), 64'd0);
      checkOutput({tag, ".dump_addr"}, 64'(dumpBus.dump_addr), 64'd0);
      checkOutput({tag, ".dump_data"}, dumpBus.dump_data, 64'd0);
      checkOutput({tag, ".dbg_reg_addr"}, 64'(dbgRegAddr), 64'd0);
      checkOutput({tag, ".step_cnt"}, 64'(stepCnt), 64'd0);
   endtask

   // Release reset with debug_mode=1 and verify the full RESET_HOLD window.
   task automatic releaseReset(input string tag);
      debugMode = 1'b1;
      aresetn   = 1'b1;
      for (int k = 1; k <= RST_HOLD; k++) begin
         tick();
         if (k == RST_HOLD - 1) checkOutput({tag, ".rstnEarly"}, 64'(coreRstn), 64'd0);
      end
      checkOutput({tag, ".rstnRise"}, 64'(coreRstn), 64'd1);
      checkOutput({tag, ".haltAfter"}, 64'(halted), 64'd1);
      checkOutput({tag, ".ceAfter"}, 64'(coreCe), 64'd0);
      checkOutput({tag, ".cntAfter"}, 64'(stepCnt), 64'd0);
   endtask

   // Press step once and measure the resulting core_ce window.
   task automatic applyStimulus(input string tag, input logic [BURST_W-1:0] len, input int expCount);
      int nCe;
      int first;
      int last;
      nCe   = 0;
      first = -1;
      last  = -1;
      burstLen = len;
      ceQ.push_back(expCount);
      step = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c == 5) step = 1'b0;
         if (coreCe) begin
            nCe++;
            if (first < 0) first = c;
            last = c;
         end
      end
      checkOutput({tag, ".first"}, 64'(first), 64'd3);
      checkOutput({tag, ".count"}, 64'(nCe), 64'(ceQ.pop_front()));
      checkOutput({tag, ".contig"}, 64'(last - first + 1), 64'(nCe));
      checkOutput({tag, ".halted"}, 64'(halted), 64'd1);
   endtask

   task automatic pulseDumpReq();
      dumpReq = 1'b1;
      tick();
      dumpReq = 1'b0;
   endtask

   task automatic loadDumpExpect();
      dumpQ.delete();
      for (int i = 0; i < NREG; i++) dumpQ.push_back({AW'(i), 64'(i) * 64'h1111});
   endtask

   initial begin
      logic [XLEN+AW-1:0] expBeat;
      logic [AW-1:0]      heldAddr;
      logic [XLEN-1:0]    heldData;
      logic               stalled;
      int                 beats;
      int                 cyc;
      int                 nCe;

      aresetn   = 1'b1;
      step      = 1'b0;
      debugMode = 1'b1;
      burstLen  = '0;
      bpEn      = 1'b0;
      bpAddr    = '0;
      pc        = '0;
      dumpReq   = 1'b0;
      dumpBus.dump_ready = 1'b0;
      #1 aresetn = 1'b0;
      tick();
      tick();
      checkResetValues("por");

      releaseReset("rel0");

      // Single step (burst_len=0 acts as 1), then a 5-cycle burst.
      applyStimulus("step0", 16'd0, 1);
      stepExp += 1;
      checkOutput("stepCnt1", 64'(stepCnt), 64'(stepExp));
      applyStimulus("step5", 16'd5, 5);
      stepExp += 5;
      checkOutput("stepCnt6", 64'(stepCnt), 64'(stepExp));

`ifdef CORE_RUN_BREAKPOINT_EN
      bpEn      = 1'b1;
      bpAddr    = 64'h40;
      pc        = 64'h0;
      debugMode = 1'b0;
      tick();
      tick();
      checkOutput("bpRunCe", 64'(coreCe), 64'd1);
      pc = 64'h40;
      #1;
      checkOutput("bpGateCe", 64'(coreCe), 64'd0);
      tick();
      debugMode = 1'b1;
      checkOutput("bpHalted", 64'(halted), 64'd1);
      applyStimulus("bpStep1", 16'd1, 1);
      applyStimulus("bpStep3", 16'd3, 1);
`else
      bpEn      = 1'b1;
      bpAddr    = 64'h40;
      pc        = 64'h40;
      debugMode = 1'b0;
      tick();
      nCe = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (coreCe) nCe++;
      end
      checkOutput("noBpRunCe", 64'(nCe), 64'd5);
      debugMode = 1'b1;
      tick();
      tick();
      checkOutput("noBpHalted", 64'(halted), 64'd1);
      applyStimulus("noBpStep3", 16'd3, 3);
`endif

      // Full dump with ready toggling every cycle.
      loadDumpExpect();
      pulseDumpReq();
      beats   = 0;
      cyc     = 0;
      stalled = 1'b0;
      heldAddr = '0;
      heldData = '0;
      while (beats < NREG && cyc < 400) begin
         tick();
         cyc++;
         dumpBus.dump_ready = cyc[0];
         if (dumpBus.dump_valid) begin
            if (stalled) begin
               checkOutput("dumpHoldAddr", 64'(dumpBus.dump_addr), 64'(heldAddr));
               checkOutput("dumpHoldData", dumpBus.dump_data, heldData);
            end
            if (dumpBus.dump_ready) begin
               expBeat = dumpQ.pop_front();
               checkOutput("dumpAddr", 64'(dumpBus.dump_addr), 64'(expBeat[XLEN+AW-1:XLEN]));
               checkOutput("dumpData", dumpBus.dump_data, expBeat[XLEN-1:0]);
               beats++;
               stalled = 1'b0;
            end else begin
               heldAddr = dumpBus.dump_addr;
               heldData = dumpBus.dump_data;
               stalled  = 1'b1;
            end
         end
      end
      checkOutput("dumpBeats", 64'(beats), 64'(NREG));
      tick();
      dumpBus.dump_ready = 1'b0;
      tick();
      checkOutput("dumpEndHalted", 64'(halted), 64'd1);
      checkOutput("dumpEndValid", 64'(dumpBus.dump_valid), 64'd0);
      checkOutput("dumpEndDbgAddr", 64'(dbgRegAddr), 64'd0);
      checkOutput("dumpQEmpty", 64'(dumpQ.size()), 64'd0);
      checkOutput("dumpEndCe", 64'(coreCe), 64'd0);

      // Reset while beat 10 of a dump is on the bus.
      loadDumpExpect();
      pulseDumpReq();
      dumpBus.dump_ready = 1'b1;
      beats = 0;
      cyc   = 0;
      while (beats < 10 && cyc < 200) begin
         tick();
         cyc++;
         if (dumpBus.dump_valid) begin
            expBeat = dumpQ.pop_front();
            checkOutput("midDumpAddr", 64'(dumpBus.dump_addr), 64'(expBeat[XLEN+AW-1:XLEN]));
            beats++;
         end
      end
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!dumpBus.dump_valid && cyc < 10);
      checkOutput("midDumpBeat10", 64'(dumpBus.dump_addr), 64'd10);
      aresetn = 1'b0;
      #1;
      checkResetValues("rstDump");
      dumpQ.delete();
      dumpBus.dump_ready = 1'b0;
      tick();
      releaseReset("rel1");

      // Reset on the third cycle of a 5-cycle burst.
      burstLen = 16'd5;
      step     = 1'b1;
      nCe      = 0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c == 5) step = 1'b0;
         if (coreCe) nCe++;
         if (nCe == 3) break;
      end
      checkOutput("midBurstCe", 64'(nCe), 64'd3);
      aresetn = 1'b0;
      step    = 1'b0;
      #1;
      checkResetValues("rstBurst");
      tick();
      releaseReset("rel2");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/core_run_ctrl.md
# core_run_ctrl

Synthesizable run controller between the board-level controls and the RV64 `Core`. It does three things:
- sequences the core's reset;
- gates core execution through a clock enable in free-run, single-step, N-step burst and PC-breakpoint modes;
- scans the register file out through the core's debug read port, one register per valid/ready handshake.

It replaces hand-driven `step`/`debug_mode`/reset stimulus with one reusable block for board and bench.

## Interface
- `XLEN`, 64: core data/PC width
- `NREG`, 32: registers scanned per dump; `AW = $clog2(NREG)`
- `RST_HOLD`, 80: cycles `core_rstn` stays low after `aresetn` deasserts; minimum 1
- `BURST_W`, 16: width of `burst_len`
- `clk` in 1: single clock
- `aresetn` in 1: asynchronous, active-low reset
- `step` in 1: raw step request, asynchronous to `clk`
- `debug_mode` in 1: 1 = halt/step mode, 0 = free-run
- `burst_len` in BURST_W: core cycles per step press; 0 is treated as 1
- `bp_en` in 1: breakpoint enable
- `bp_addr` in XLEN: breakpoint PC
- `pc` in XLEN: current core PC
- `dump_req` in 1: register-dump request, one-cycle pulse
- `dbg_reg_data` in XLEN: core debug read data
- `dump_ready` in 1: consumer accepts the current dump beat
- `core_rstn` out 1: core reset, active low
- `core_ce` out 1: core clock enable
- `halted` out 1: high while in HALT or DUMP
- `dbg_reg_addr` out AW: core debug read address
- `dump_valid` out 1: dump beat valid
- `dump_addr` out AW: register index of the current beat
- `dump_data` out XLEN: register value of the current beat
- `step_cnt` out 32: count of cycles with `core_ce`=1; wraps at 2^32

## Operation
- States: RESET_HOLD, RUN, HALT, STEP, DUMP.
- **Reset values (`aresetn`=0):**
  - state = RESET_HOLD;
  - `core_rstn`, `core_ce`, `halted`, `dump_valid` = 0;
  - `dbg_reg_addr`, `dump_addr`, `dump_data`, `step_cnt` = 0;
  - step synchronizer flops = 0, dump-pending flag = 0.
- **RESET_HOLD:** counts RST_HOLD cycles, then sets `core_rstn`=1. In that same cycle it goes to HALT if `debug_mode`=1, otherwise to RUN.
- **RUN:**
  - `core_ce`=1.
  - `debug_mode`=1 → HALT.
  - Breakpoint hit (`bp_en` and `pc`==`bp_addr`) → `core_ce` is forced to 0 combinationally in that cycle; next state is HALT.
- **HALT:**
  - `core_ce`=0, `halted`=1.
  - Priority order: pending dump → DUMP; else step rising edge → STEP, remaining = max(`burst_len`,1); else `debug_mode`=0 → RUN.
- **STEP:**
  - `core_ce`=1; remaining decrements each cycle.
  - Returns to HALT after the cycle in which remaining was 1.
  - Breakpoint is ignored on the first STEP cycle, so a halted breakpoint can be stepped past. On later cycles a hit ends the burst early, with the same combinational gating as in RUN.
- **`step` input:** 2-flop synchronizer plus rising-edge detector. Edges outside HALT are discarded.
- **`dump_req`:** sets a pending flag in any state other than RESET_HOLD. The flag is cleared on entry to DUMP.
- **DUMP:**
  - `core_ce`=0.
  - Index i runs 0..NREG-1. `dbg_reg_addr`=i; `dbg_reg_data` is captured the following cycle into `dump_data`, with `dump_addr`=i and `dump_valid`=1.
  - The beat holds until `dump_ready`=1; then i increments.
  - After beat NREG-1 is accepted → HALT, with `dbg_reg_addr` back to 0.
- `step_cnt` increments in every cycle where `core_ce`=1.

## Timing
- Reset sequencing: `core_rstn` rises exactly RST_HOLD clock edges after the first edge with `aresetn`=1.
- Step latency: `step` rising edge to first `core_ce` cycle is 3 clocks (2 synchronizer flops + state register).
- Dump beat: 1 cycle of address setup, then `dump_valid`. One beat takes at minimum 2 cycles; a full dump of NREG=32 with `dump_ready` held high takes 64 cycles.
- Valid/ready rule: `dump_addr` and `dump_data` are stable while `dump_valid`=1 and `dump_ready`=0. `dump_valid` never drops without acceptance, except on reset.
- Asserting `aresetn`=0 at any time, mid-burst or mid-dump, immediately forces the reset values. No partial beat completes.
- `debug_mode` changes during STEP or DUMP take effect only after returning to HALT.

## Configuration
- `CORE_RUN_BREAKPOINT_EN` defined: breakpoint compare and combinational `core_ce` gating are built in, as described above.
- Not defined: `bp_en`, `bp_addr` and `pc` are ignored. RUN leaves only on `debug_mode`=1, and STEP always runs its full burst.

## Test plan
- RST_HOLD=80, `debug_mode`=1, release `aresetn` → `core_rstn` rises on edge 80; state HALT; `core_ce`=0; `step_cnt`=0.
- In HALT, `burst_len`=0, one `step` pulse → exactly 1 `core_ce` cycle starting 3 clocks later; `step_cnt`=1. Repeat with `burst_len`=5 → 5 consecutive cycles; `step_cnt`=6.
- Macro defined, RUN, `bp_addr`=0x40, `pc` reaches 0x40 → `core_ce`=0 in that cycle; `halted`=1 next cycle. One step with `burst_len`=1 → exactly 1 cycle executed despite `pc`=0x40.
- `dump_req` in HALT, `dump_ready` toggling 1/0, model regfile with x_i = i·0x1111 → 32 beats, addresses 0..31 in order, data correct, stable while stalled; then HALT.
- `aresetn` asserted at beat 10 of a dump and at cycle 3 of a 5-cycle burst → all outputs at reset values immediately; RESET_HOLD repeats in full.
- Macro undefined, `pc`==`bp_addr`, `bp_en`=1, free-run → `core_ce` stays 1.
